// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   UART_LF          line terminator byte
//   uart_byte_t      one received byte
//   uart_rx_state_t  bit-level receiver FSM states
package uart_pkg;

    localparam logic [7:0] UART_LF = 8'h0A;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver (synchroniser + bit FSM + baud counter).
//   clk, rst_n  system clock, async active-low reset
//   rx          raw UART input, idle high, asynchronous to clk
//   rx_byte     last assembled byte (valid while byte_vld is high)
//   byte_vld    one-cycle pulse: good byte, stop bit sampled 1
//   frame_err   one-cycle pulse: stop bit sampled 0, byte dropped
//   idle        FSM is in IDLE (used by the line-level timeout)
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output uart_byte_t rx_byte,
    output logic       byte_vld,
    output logic       frame_err,
    output logic       idle
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

    logic           rx_meta, rx_sync, rx_prev;
    uart_rx_state_t state, nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    uart_byte_t     shreg;
    logic           half_tick, full_tick;

    assign half_tick = (cnt == HALF);
    assign full_tick = (cnt == FULL);
    assign rx_byte   = shreg;

    // Two-flop synchroniser plus one more stage for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (rx_prev && !rx_sync)     nxt = START;
            START:   if (half_tick)               nxt = rx_sync ? IDLE : DATA;
            DATA:    if (full_tick && &bit_idx)   nxt = STOP;
            STOP:    if (full_tick)               nxt = rx_sync ? IDLE : WAIT_HI;
            WAIT_HI: if (rx_sync)                 nxt = IDLE;
            default:                              nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_vld  = (state == STOP) && full_tick &&  rx_sync;
        frame_err = (state == STOP) && full_tick && !rx_sync;
        idle      = (state == IDLE);
    end

    // Baud counter restarts on every state change so START times a half
    // bit from the edge and DATA/STOP land in the middle of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state != nxt || (state == DATA && full_tick)) cnt <= '0;
            else                                              cnt <= cnt + 1'b1;
            if (state == START) bit_idx <= '0;
            if (state == DATA && full_tick) begin
                shreg   <= {rx_sync, shreg[7:1]};   // LSB first
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_line.sv
// uart_rx_line: assembles UART bytes into LF-terminated lines of up to 8 bytes.
//   clk, rst_n  system clock, async active-low reset
//   i_rx        UART serial input, idle high
//   o_data      received line, first byte of a full line in [7], last in [0]
//   o_len       valid bytes in o_data (0..8)
//   o_valid     one-cycle strobe qualifying o_data/o_len/o_err/o_ovf
//   o_err       framing error seen during this line
//   o_ovf       more than 8 non-LF bytes seen; extras dropped
// Optional: define UART_RX_LINE_TIMEOUT_EN to flush a partial line after
// UART_RX_TIMEOUT_BITS idle bit-times.
module uart_rx_line
    import uart_pkg::*;
#(
    parameter int UART_RX_CLK_DIV      = 434,
    parameter int UART_RX_TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_rx,
    output logic [7:0][7:0] o_data,
    output logic [3:0]      o_len,
    output logic            o_valid,
    output logic            o_err,
    output logic            o_ovf
);

    uart_byte_t      rx_byte;
    logic            byte_vld, frame_err, rx_idle;
    logic [7:0][7:0] asm_data;
    logic [3:0]      count;
    logic            err_flag, ovf_flag;
    logic            to_flush, lf_flush, flush;

    uart_rx_byte #(.CLK_DIV(UART_RX_CLK_DIV)) u_byte (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (i_rx),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (frame_err),
        .idle      (rx_idle)
    );

`ifdef UART_RX_LINE_TIMEOUT_EN
    localparam int TO_CYC = UART_RX_TIMEOUT_BITS * UART_RX_CLK_DIV;
    localparam int TW     = $clog2(TO_CYC + 1);
    logic [TW-1:0] idle_cnt;

    assign to_flush = rx_idle && (count != 4'd0) && (idle_cnt == TW'(TO_CYC - 1));

    // Leaving IDLE (start edge) or an empty line holds the counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          idle_cnt <= '0;
        else if (!rx_idle || count == 4'd0 || to_flush) idle_cnt <= '0;
        else                                 idle_cnt <= idle_cnt + 1'b1;
    end
`else
    localparam int UNUSED_TIMEOUT_BITS = UART_RX_TIMEOUT_BITS;
    logic unused_idle;
    assign unused_idle = rx_idle;
    assign to_flush    = 1'b0;
`endif

    assign lf_flush = byte_vld && (rx_byte == UART_LF);
    assign flush    = lf_flush || to_flush;

    // asm_data is not cleared on flush: an empty line therefore re-presents
    // the previous line's bytes, keeping o_data unchanged for o_len=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_data <= '0;
            count    <= '0;
            err_flag <= 1'b0;
            ovf_flag <= 1'b0;
            o_data   <= '0;
            o_len    <= '0;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_ovf    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (frame_err) err_flag <= 1'b1;
            if (flush) begin
                o_valid  <= 1'b1;
                o_data   <= asm_data;
                o_len    <= count;
                o_err    <= err_flag;
                o_ovf    <= ovf_flag;
                count    <= '0;
                err_flag <= 1'b0;
                ovf_flag <= 1'b0;
            end else if (byte_vld) begin
                if (count < 4'd8) begin
                    asm_data <= {asm_data[6:0], rx_byte};
                    count    <= count + 1'b1;
                end else begin
                    ovf_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_line.sv
module tb_uart_rx_line;

    localparam int DIV = 32;    // short bit time keeps the run small

    typedef struct {
        logic [3:0]  len;
        logic [63:0] data;
        logic        err;
        logic        ovf;
    } line_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_rx = 1'b1;
    logic [7:0][7:0] o_data;
    logic [3:0]      o_len;
    logic            o_valid, o_err, o_ovf;

    line_t exp_q[$];
    line_t obs_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_line #(.UART_RX_CLK_DIV(DIV), .UART_RX_TIMEOUT_BITS(20)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_rx    (i_rx),
        .o_data  (o_data),
        .o_len   (o_len),
        .o_valid (o_valid),
        .o_err   (o_err),
        .o_ovf   (o_ovf)
    );

    // Capture every strobe the DUT produces.
    always @(negedge clk) begin
        if (o_valid) begin
            line_t o;
            o.len = o_len; o.data = o_data; o.err = o_err; o.ovf = o_ovf;
            obs_q.push_back(o);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk) i_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        i_rx = stop_bit;
        repeat (DIV) @(negedge clk);
        if (stop_bit) i_rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic wait_strobe(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            if (obs_q.size() > 0) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (o_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", o_data); end
        n_cmp++; if (o_len !== 4'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", o_len); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_cmp++; if ({o_err, o_ovf} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {o_err, o_ovf}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_full_line;
        bit got; line_t e, o;
        exp_q.push_back('{4'd8, "ABCDEFGH", 1'b0, 1'b0});
        send_str("ABCDEFGH\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL full_line: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL full_line: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask

    task automatic test_empty_line;
        bit got; line_t e, o;
        exp_q.push_back('{4'd0, "ABCDEFGH", 1'b0, 1'b0});
        send_str("\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL empty_line: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL empty_line: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask

    task automatic test_overflow;
        bit got; line_t e, o;
        exp_q.push_back('{4'd8, "01234567", 1'b0, 1'b1});
        send_str("0123456789\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL ovf_line: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL ovf_line: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
        // Next line: flag cleared, assembly register keeps shifting.
        exp_q.push_back('{4'd2, "234567XY", 1'b0, 1'b0});
        send_str("XY\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL after_ovf: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL after_ovf: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask

    task automatic test_framing;
        bit got; line_t e, o;
        send_byte("Z", 1'b0);
        repeat (3 * DIV) @(negedge clk);
        i_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL frame_nostrobe: got %0d strobes want 0", obs_q.size()); obs_q.delete(); end
        exp_q.push_back('{4'd1, "34567XYQ", 1'b1, 1'b0});
        send_str("Q\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL frame_line: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL frame_line: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask

    task automatic test_glitch;
        @(negedge clk) i_rx = 1'b0;
        repeat (DIV * 3 / 10) @(negedge clk);
        i_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch: got %0d strobes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid;
        bit got; line_t e, o;
        logic [7:0] b;
        b = 8'h55;
        send_str("R");                       // partial line that must vanish
        @(negedge clk) i_rx = 1'b0;          // start of a byte, cut short
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 3; i++) begin i_rx = b[i]; repeat (DIV) @(negedge clk); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({o_data, o_len, o_valid, o_err, o_ovf} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got data=%h len=%0d v=%b err=%b ovf=%b want all 0",
                     o_data, o_len, o_valid, o_err, o_ovf);
        end
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        exp_q.push_back('{4'd1, 64'h4B, 1'b0, 1'b0});
        send_str("K\n");
        wait_strobe(4 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL after_reset: no strobe, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL after_reset: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask

`ifdef UART_RX_LINE_TIMEOUT_EN
    task automatic test_timeout;
        bit got; line_t e, o;
        exp_q.push_back('{4'd2, 64'h4B4142, 1'b0, 1'b0});
        send_str("AB");
        wait_strobe(25 * DIV, got);
        n_cmp++;
        if (!got) begin n_bad++; $display("FAIL timeout: no strobe within 25 bit-times, want one"); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if ({o.len, o.data, o.err, o.ovf} !== {e.len, e.data, e.err, e.ovf}) begin
                n_bad++;
                $display("FAIL timeout: got len=%0d data=%h err=%b ovf=%b want len=%0d data=%h err=%b ovf=%b",
                         o.len, o.data, o.err, o.ovf, e.len, e.data, e.err, e.ovf);
            end
        end
    endtask
`else
    task automatic test_timeout;
        send_str("AB");
        repeat (100 * DIV) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL no_timeout: got %0d strobes want 0", obs_q.size()); obs_q.delete(); end
    endtask
`endif

    initial begin
        test_reset;
        test_full_line;
        test_empty_line;
        test_overflow;
        test_framing;
        test_glitch;
        test_reset_mid;
        test_timeout;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got obs=%0d exp=%0d want 0/0", obs_q.size(), exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
